// File: rtl/cla_pkg.sv
// Shared constants and operation-mode encoding for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_BLOCK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe; slave is the adder's view.
interface cla_adder_pipe_if
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/cla_group.sv
// One BLOCK-bit lookahead group: group propagate/generate and sum bits from per-bit p/g
// and the group carry-in.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] p,
  input  logic [BLOCK-1:0] g,
  input  logic             cin,
  output logic             gp,
  output logic             gg,
  output logic [BLOCK-1:0] s
);

  logic [BLOCK-1:0] c;

  always_comb begin
    c    = '0;
    gg   = 1'b0;
    c[0] = cin;
    for (int i = 1; i < BLOCK; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    for (int i = 0; i < BLOCK; i++) begin
      gg = g[i] | (p[i] & gg);
    end
  end

  assign gp = &p;
  assign s  = p ^ c;

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers per-bit and per-group P/G; stage 2 resolves group carries and the flags.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input logic            clk,
  input logic            rst,
  cla_adder_pipe_if.slave bus
);

  localparam int NGRP = WIDTH / BLOCK;

  if (((WIDTH % BLOCK) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK and at least 8");
  end

  mode_e            mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] g_next;
  logic             c_next;
  logic [NGRP-1:0]  gp_next;
  logic [NGRP-1:0]  gg_next;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] g_reg;
  logic             c_reg;
  logic [NGRP-1:0]  gp_reg;
  logic [NGRP-1:0]  gg_reg;

  logic [NGRP:0]    gc;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;
  logic             zero_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic             out_adv;
  logic             s1_adv;

  assign out_adv = ~out_valid_reg | bus.out_ready;
  assign s1_adv  = ~s1_valid_reg | out_adv;

  assign mode   = mode_e'(bus.sub);
  assign b_eff  = (mode == MODE_SUB) ? ~bus.b : bus.b;
  assign p_next = bus.a ^ b_eff;
  assign g_next = bus.a & b_eff;
  assign c_next = bus.cin ^ bus.sub;

  // Stage-1 copies feed only group P/G, stage-2 copies only sums; the idle outputs are dropped.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [BLOCK-1:0] unused_s;
    logic             unused_gp;
    logic             unused_gg;

    cla_group #(.BLOCK(BLOCK)) u_pg (
      .p   (p_next[gi*BLOCK +: BLOCK]),
      .g   (g_next[gi*BLOCK +: BLOCK]),
      .cin (1'b0),
      .gp  (gp_next[gi]),
      .gg  (gg_next[gi]),
      .s   (unused_s)
    );

    cla_group #(.BLOCK(BLOCK)) u_sum (
      .p   (p_reg[gi*BLOCK +: BLOCK]),
      .g   (g_reg[gi*BLOCK +: BLOCK]),
      .cin (gc[gi]),
      .gp  (unused_gp),
      .gg  (unused_gg),
      .s   (sum_next[gi*BLOCK +: BLOCK])
    );
  end

  // Each group carry is a flat sum of products over all lower groups, not a ripple chain.
  always_comb begin : group_lookahead
    logic carry;
    logic prop;
    gc    = '0;
    carry = 1'b0;
    prop  = 1'b1;
    gc[0] = c_reg;
    for (int i = 0; i < NGRP; i++) begin
      carry = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prop = 1'b1;
        for (int k = j + 1; k <= i; k++) begin
          prop = prop & gp_reg[k];
        end
        carry = carry | (gg_reg[j] & prop);
      end
      prop = 1'b1;
      for (int k = 0; k <= i; k++) begin
        prop = prop & gp_reg[k];
      end
      gc[i+1] = carry | (prop & c_reg);
    end
  end

  // A clear MSB propagate means a and b_eff share a sign, and that sign is the MSB generate.
  assign cout_next = gc[NGRP];
  assign ovf_next  = ~p_reg[WIDTH-1] & (sum_next[WIDTH-1] ^ g_reg[WIDTH-1]);
  assign zero_next = ~|sum_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      p_reg        <= '0;
      g_reg        <= '0;
      c_reg        <= 1'b0;
      gp_reg       <= '0;
      gg_reg       <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        p_reg  <= p_next;
        g_reg  <= g_next;
        c_reg  <= c_next;
        gp_reg <= gp_next;
        gg_reg <= gg_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
    end else if (out_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg  <= sum_next;
        cout_reg <= cout_next;
        ovf_reg  <= ovf_next;
        zero_reg <= zero_next;
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe at 16/4 and 32/8: directed vectors, backpressure and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_cla_adder_pipe;
  import cla_pkg::*;

  localparam int W1 = 16, B1 = 4, W2 = 32, B2 = 8;

  typedef struct packed {
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [31:0] sum;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    mode_e       mode;
    logic [15:0] sum;
    bit          cout;
    bit          ovf;
    bit          zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(W1)) bus16 ();
  cla_adder_pipe_if #(.WIDTH(W2)) bus32 ();

  cla_adder_pipe #(.WIDTH(W1), .BLOCK(B1)) u16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  cla_adder_pipe #(.WIDTH(W2), .BLOCK(B2)) u32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  int   n_cmp = 0;
  int   n_err = 0;
  res_t q16[$];
  res_t q32[$];
  bit   stall_prev[2];
  res_t prev_r[2];
  int   delivered[2];
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands, no P/G modelling.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input bit cin, input bit sub);
    longint m, ua, ub, sa, sb, ur, sr;
    res_t   r;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sub) begin
      ur     = ua + ub + longint'(cin);
      sr     = sa + sb + longint'(cin);
      r.cout = (ur >= m);
    end else begin
      ur     = ua - ub - longint'(cin);
      sr     = sa - sb - longint'(cin);
      r.cout = (ur >= 0);
    end
    r.sum  = 32'(ur & (m - 1));
    r.ovf  = (sr >= m / 2) || (sr < -(m / 2));
    r.zero = (r.sum == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] top;
    top = 32'h1 << (w - 1);
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return (top << 1) - 32'h1;
      2:       return top;
      3:       return top - 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q16.size() : q32.size();
  endfunction

  task automatic drive(input int d, input bit iv, input logic [31:0] a, input logic [31:0] b,
                       input bit cin, input bit sub, input bit ordy);
    if (d == 0) begin
      bus16.in_valid = iv; bus16.a = a[15:0]; bus16.b = b[15:0];
      bus16.cin = cin; bus16.sub = sub; bus16.out_ready = ordy;
    end else begin
      bus32.in_valid = iv; bus32.a = a; bus32.b = b;
      bus32.cin = cin; bus32.sub = sub; bus32.out_ready = ordy;
    end
  endtask

  task automatic sample(input int d, output bit ir, output bit ov, output res_t r);
    if (d == 0) begin
      ir = bus16.in_ready; ov = bus16.out_valid;
      r  = {bus16.cout, bus16.ovf, bus16.zero, 16'h0, bus16.sum};
    end else begin
      ir = bus32.in_ready; ov = bus32.out_valid;
      r  = {bus32.cout, bus32.ovf, bus32.zero, bus32.sum};
    end
  endtask

  // One clock of traffic: drive at the falling edge, then score what the next rising edge does.
  task automatic cyc(input int d, input bit iv, input logic [31:0] a, input logic [31:0] b,
                     input bit cin, input bit sub, input bit ordy, output bit acc, output bit ir);
    bit   ov;
    res_t r, e;
    int   occ;
    @(negedge clk);
    drive(d, iv, a, b, cin, sub, ordy);
    #1;
    sample(d, ir, ov, r);
    occ = qsize(d);
    chk($sformatf("in_ready%0d", d), 64'(ir), 64'((occ < 2) || ordy));
    if (stall_prev[d]) begin
      chk($sformatf("hold_valid%0d", d), 64'(ov), 64'd1);
      chk($sformatf("hold_data%0d", d), 64'(r), 64'(prev_r[d]));
    end
    if (ov && ordy) begin
      if (occ == 0) begin
        chk($sformatf("spurious_out%0d", d), 64'(ov), 64'd0);
      end else begin
        e = (d == 0) ? q16.pop_front() : q32.pop_front();
        chk($sformatf("result%0d", d), 64'(r), 64'(e));
        delivered[d]++;
        $display("dut%0d beat %0d sum=%h cout=%b ovf=%b zero=%b", d, delivered[d],
                 r.sum, r.cout, r.ovf, r.zero);
      end
    end
    acc = iv && ir;
    if (acc) begin
      if (d == 0) q16.push_back(model(W1, a, b, cin, sub));
      else        q32.push_back(model(W2, a, b, cin, sub));
    end
    stall_prev[d] = ov && !ordy;
    prev_r[d]     = r;
  endtask

  // Single beat into an empty pipe; result must appear exactly on the second edge.
  task automatic apply_vec(input vec_t v, input int idx);
    bit   ir, ov;
    res_t r;
    @(negedge clk);
    drive(0, 1'b1, {16'h0, v.a}, {16'h0, v.b}, v.cin, v.mode == MODE_SUB, 1'b1);
    #1;
    sample(0, ir, ov, r);
    chk($sformatf("vec%0d_in_ready", idx), 64'(ir), 64'd1);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    sample(0, ir, ov, r);
    chk($sformatf("vec%0d_early_valid", idx), 64'(ov), 64'd0);
    @(negedge clk);
    #1;
    sample(0, ir, ov, r);
    chk($sformatf("vec%0d_valid", idx), 64'(ov), 64'd1);
    chk($sformatf("vec%0d_result", idx), 64'(r), 64'({v.cout, v.ovf, v.zero, 16'h0, v.sum}));
    $display("vec %0d: %h %s %h cin=%b -> sum=%h cout=%b ovf=%b zero=%b", idx, v.a,
             (v.mode == MODE_SUB) ? "-" : "+", v.b, v.cin, r.sum, r.cout, r.ovf, r.zero);
  endtask

  task automatic rand_run(input int d, input int nbeats);
    int          w = (d == 0) ? W1 : W2;
    int          sent = 0;
    int          n = 0;
    bit          acc, ir, iv, ordy, cin, sub;
    logic [31:0] a, b;
    while ((sent < nbeats || qsize(d) != 0) && n < 40000) begin
      iv   = (sent < nbeats) && ($urandom_range(0, 9) < 7);
      ordy = $urandom_range(0, 9) < 7;
      a    = pick(w);
      b    = pick(w);
      cin  = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      cyc(d, iv, a, b, cin, sub, ordy, acc, ir);
      if (acc) sent++;
      n++;
    end
    chk($sformatf("rand%0d_in_budget", d), 64'(n < 40000), 64'd1);
    chk($sformatf("rand%0d_sent", d), 64'(sent), 64'(nbeats));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc, ir, ov;
    res_t r;
    int   sent, c, start;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{16'h8000, 16'h0001, 1'b0, MODE_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b0, MODE_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h0005, 16'h0007, 1'b1, MODE_SUB, 16'hFFFD, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b1, MODE_ADD, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{16'h1234, 16'h1234, 1'b0, MODE_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b1, MODE_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h7FFF, 16'h7FFF, 1'b1, MODE_ADD, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{16'h00FF, 16'h0F01, 1'b0, MODE_ADD, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{16'hFFFF, 16'h0000, 1'b1, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};

    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Reset state
    @(posedge clk);
    @(negedge clk);
    #1;
    sample(0, ir, ov, r);
    chk("reset_out_valid16", 64'(ov), 64'd0);
    chk("reset_in_ready16", 64'(ir), 64'd1);
    chk("reset_outputs16", 64'(r), 64'd0);
    sample(1, ir, ov, r);
    chk("reset_out_valid32", 64'(ov), 64'd0);
    chk("reset_outputs32", 64'(r), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply_vec(tbl[i], i);
    end

    // Four back-to-back beats with the consumer stalled for cycles 2..4
    sent  = 0;
    c     = 0;
    start = delivered[0];
    while ((sent < 4 || q16.size() != 0) && c < 30) begin
      cyc(0, sent < 4, 32'(sent) * 32'h1111 + 32'h0FF0, 32'h0010 + 32'(sent), 1'(sent),
          1'(sent >> 1), !(c >= 2 && c < 5), acc, ir);
      if (c >= 2 && c < 5) begin
        chk($sformatf("bp_in_ready_c%0d", c), 64'(ir), 64'd0);
        chk($sformatf("bp_accepted_c%0d", c), 64'(sent), 64'd2);
      end
      if (acc) sent++;
      c++;
    end
    chk("bp_delivered", 64'(delivered[0] - start), 64'd4);
    chk("bp_in_budget", 64'(c < 30), 64'd1);

    // Fill both stages, then reset for one cycle
    cyc(0, 1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0, acc, ir);
    cyc(0, 1'b1, 32'h0000_3333, 32'h0000_4444, 1'b1, 1'b1, 1'b0, acc, ir);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    sample(0, ir, ov, r);
    chk("pre_reset_full", 64'(ov && !ir), 64'd1);
    rst = 1'b1;
    #1;
    sample(0, ir, ov, r);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_outputs", 64'(r), 64'd0);
    chk("rst_in_ready", 64'(ir), 64'd1);
    q16.delete();
    stall_prev[0] = 1'b0;
    start = delivered[0];
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 1'b1, 1'b1);
    #1;
    sample(0, ir, ov, r);
    chk("post_reset_in_ready", 64'(ir), 64'd1);
    chk("post_reset_out_valid", 64'(ov), 64'd0);
    q16.push_back(model(W1, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc, ir);
    end
    chk("post_reset_delivered", 64'(delivered[0] - start), 64'd1);

    fork
      rand_run(0, 10000);
      rand_run(1, 10000);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of BLOCK, minimum 8.
REQ-002 Parameter BLOCK, default 4, bits per carry-lookahead group.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (borrow-in when sub=1).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB (in subtract mode, 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum equals 0.

Function
REQ-017 Effective operand SHALL be b_eff = sub ? ~b : b; effective carry-in SHALL be c_eff = cin XOR sub.
REQ-018 Result SHALL be {cout,sum} = a + b_eff + c_eff, computed modulo 2^(WIDTH+1).
REQ-019 ovf SHALL be (a[MSB] == b_eff[MSB]) AND (sum[MSB] != a[MSB]).
REQ-020 Stage 1 SHALL register per-bit p = a XOR b_eff, per-group propagate/generate, and c_eff.
REQ-021 Stage 2 SHALL compute group carries by lookahead across all WIDTH/BLOCK groups from registered P/G, then register sum, cout, ovf and zero.
REQ-022 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid when out_ready is held high.
REQ-023 A beat SHALL be accepted on an edge where in_valid AND in_ready are both 1.
REQ-024 Each stage SHALL advance when it is empty or the stage after it advances; out stage advances when out_valid=0 or out_ready=1.
REQ-025 in_ready SHALL equal (stage-1 empty) OR (stage 1 advances); it SHALL NOT depend on in_valid.
REQ-026 With out_ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-027 While out_valid=1 and out_ready=0, sum, cout, ovf and zero SHALL hold stable.
REQ-028 With both stages full and out_ready=0, in_ready SHALL be 0 and no beat is lost or duplicated.
REQ-029 Beats SHALL leave in acceptance order.

Reset
REQ-030 On rst=1, both stage valid bits SHALL clear immediately; out_valid=0; sum=0, cout=0, ovf=0, zero=0.
REQ-031 A beat in flight at reset assertion SHALL be discarded and never presented.
REQ-032 in_ready SHALL be 1 during reset; the first edge after rst deasserts SHALL be able to accept a beat.

Structure
REQ-033 Package cla_pkg SHALL hold default WIDTH and BLOCK constants and a mode enum (MODE_ADD=0, MODE_SUB=1).
REQ-034 Sub-module cla_group SHALL implement one BLOCK-bit group: group P/G, and sums from per-bit p/g plus a group carry-in; cla_adder_pipe SHALL instantiate WIDTH/BLOCK copies via generate.
REQ-035 An elaboration-time check SHALL reject WIDTH not divisible by BLOCK.

Verification (WIDTH=16, BLOCK=4)
REQ-036 Add 0xFFFF + 0x0001, cin=0, sub=0 -> two cycles later sum=0x0000, cout=1, zero=1, ovf=0.
REQ-037 Add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0; sub 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-038 Sub 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0; sub 0x0005 - 0x0007, cin=1 -> sum=0xFFFD.
REQ-039 Stream 4 beats back-to-back, out_ready=0 from cycle 2 for 3 cycles -> in_ready drops after 2 accepted, outputs hold, all 4 results emerge in order.
REQ-040 Assert rst for one cycle with both stages full -> out_valid=0 immediately, discarded beats never appear, next beat accepted the cycle after release.
REQ-041 Random 10k beats with random in_valid/out_ready against a+b_eff+c_eff reference model, also at WIDTH=32, BLOCK=8 -> zero mismatches.
